// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and elaboration helpers for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RELEASE = 3'd1,
    RUN     = 3'd2,
    ASSERT  = 3'd3,
    ACK     = 3'd4
  } seqState_t;

  function automatic int idxWidth(input int numStages);
    return (numStages <= 1) ? 1 : $clog2(numStages);
  endfunction

  // Counter must hold STAGE_DELAY-1; widths of 31 and above always fit an int delay.
  function automatic bit paramsOk(input int numStages, input int stageDelay,
                                  input int cntW, input int syncStages);
    return (numStages >= 1) && (numStages <= 8) && (stageDelay >= 1) &&
           (syncStages >= 2) && (cntW >= 1) &&
           ((cntW >= 31) || ((stageDelay - 1) < (1 << cntW)));
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - soft-reset handshake and per-domain reset bundle
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  iSoftRstReq;
  logic                  oSoftRstAck;
  logic [NUM_STAGES-1:0] oStageRst_n;
  logic                  oAllReleased;
  logic                  oBusy;

  modport master (
    output iSoftRstReq,
    input  oSoftRstAck, oStageRst_n, oAllReleased, oBusy
  );

  modport slave (
    input  iSoftRstReq,
    output oSoftRstAck, oStageRst_n, oAllReleased, oBusy
  );
endinterface

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - async-assert, sync-deassert reset release synchroniser
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iRst_n,
  output logic oRstSync
);

  logic [SYNC_STAGES-1:0] chain;

  if (SYNC_STAGES < 2) begin : gBadDepth
    $error("reset_sync: SYNC_STAGES must be at least 2");
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign oRstSync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of reset domains with soft-reset handshake
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        iClk,
  input  logic        iRst_n,
  reset_sequencer_if.slave bus
);

  localparam int                IDX_W    = idxWidth(NUM_STAGES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_STAGES - 1);

  if (!paramsOk(NUM_STAGES, STAGE_DELAY, CNT_W, SYNC_STAGES)) begin : gBadParams
    $error("reset_sequencer: illegal parameter combination");
  end

  seqState_t             stateQ, stateD;
  logic [CNT_W-1:0]      cntQ, cntD;
  logic [IDX_W-1:0]      idxQ, idxD;
  logic [NUM_STAGES-1:0] stageQ, stageD;
  logic                  ackQ, ackD;
  logic                  allRelQ, allRelD;
  logic                  busyQ, busyD;
  logic                  rstSync;
  logic                  termCnt;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .oRstSync(rstSync)
  );

  assign termCnt = (cntQ == CNT_LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ  <= HOLD;
      cntQ    <= '0;
      idxQ    <= '0;
      stageQ  <= '0;
      ackQ    <= 1'b0;
      allRelQ <= 1'b0;
      busyQ   <= 1'b1;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      idxQ    <= idxD;
      stageQ  <= stageD;
      ackQ    <= ackD;
      allRelQ <= allRelD;
      busyQ   <= busyD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    idxD    = idxQ;
    stageD  = stageQ;
    ackD    = ackQ;
    allRelD = allRelQ;
    busyD   = busyQ;
    case (stateQ)
      // HOLD releases stage 0 (index is 0 there); RELEASE continues upward.
      HOLD, RELEASE: begin
        if (rstSync) begin
          if (termCnt) begin
            cntD         = '0;
            stageD[idxQ] = 1'b1;
            if (idxQ == IDX_LAST) begin
              stateD  = RUN;
              allRelD = 1'b1;
              busyD   = 1'b0;
            end else begin
              idxD   = idxQ + 1'b1;
              stateD = RELEASE;
            end
          end else begin
            cntD = cntQ + 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.iSoftRstReq) begin
          stateD  = ASSERT;
          idxD    = IDX_LAST;
          allRelD = 1'b0;
          busyD   = 1'b1;
        end
      end
      ASSERT: begin
        stageD[idxQ] = 1'b0;
        if (idxQ == '0) begin
          stateD = ACK;
        end else begin
          idxD = idxQ - 1'b1;
        end
      end
      ACK: begin
        // Ack is always raised for at least one cycle, even if the request already dropped.
        if (!ackQ) begin
          ackD = 1'b1;
        end else if (!bus.iSoftRstReq) begin
          ackD   = 1'b0;
          cntD   = '0;
          stateD = HOLD;
        end
      end
      default: begin
        stateD = HOLD;
      end
    endcase
  end

  assign bus.oStageRst_n  = stageQ;
  assign bus.oSoftRstAck  = ackQ;
  assign bus.oAllReleased = allRelQ;
  assign bus.oBusy        = busyQ;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the board-level power-on reset and releases NUM_STAGES downstream reset domains in a fixed order, with a programmable gap between releases. Used for clocking, then CSR, then datapath, then I/O.
- Synchronises reset release into iClk.
- Provides a 4-phase soft-reset handshake. It re-asserts all domains in reverse order, acknowledges, then re-runs the release sequence.
- Sits directly behind the reset generator, at the top of every CPLD image.

Parameters:
- NUM_STAGES, 4: number of sequenced reset domains. Legal range 1..8.
- STAGE_DELAY, 16: iClk cycles between consecutive releases. Must be >= 1.
- CNT_W, 16: delay counter width. Elaboration error if STAGE_DELAY-1 does not fit in CNT_W.
- SYNC_STAGES, 2: depth of the release synchroniser. Must be >= 2.

Ports:
- iClk, input, 1: system clock.
- iRst_n, input, 1: asynchronous, active-low reset. Asserts asynchronously; release is synchronised internally.
- iSoftRstReq, input, 1: soft-reset request, level, synchronous to iClk.
- oSoftRstAck, output, 1: soft-reset acknowledge, level.
- oStageRst_n, output, NUM_STAGES: per-domain active-low resets. Bit 0 is released first.
- oAllReleased, output, 1: high while every domain is released.
- oBusy, output, 1: high while a release or assert sequence is in progress.

Behaviour:

Reset
- iRst_n low: all flops clear asynchronously.
- Outputs during reset: oStageRst_n = 0, oSoftRstAck = 0, oAllReleased = 0, oBusy = 1.
- State = HOLD, counter = 0, stage index = 0, synchroniser chain = 0.

Synchroniser
- Shifts in 1 each edge once iRst_n is high.
- Its output (rstSync) goes high on the SYNC_STAGES-th rising edge after iRst_n deasserts.

Counter rule
- Counts 0 .. STAGE_DELAY-1.
- At STAGE_DELAY-1, the next edge performs the stage action and reloads 0.
- STAGE_DELAY = 1 gives one action per cycle.

States (registered Moore outputs)
- HOLD
  - Waits for rstSync = 1; the counter runs only when rstSync = 1.
  - On terminal count: set oStageRst_n[0] = 1 and index = 1.
  - Then go to RELEASE, or go straight to RUN if NUM_STAGES = 1.
- RELEASE
  - On each terminal count: set oStageRst_n[index] = 1 and increment index.
  - When index reaches NUM_STAGES: go to RUN.
  - On the same edge as the last stage release, set oAllReleased = 1 and oBusy = 0.
- RUN
  - All stages released.
  - iSoftRstReq = 1: go to ASSERT with index = NUM_STAGES-1, and set oAllReleased = 0, oBusy = 1 on that edge.
- ASSERT
  - One stage per cycle, highest first: oStageRst_n[index] = 0, then decrement index.
  - After bit 0 is cleared: go to ACK. No STAGE_DELAY on assertion.
- ACK
  - oSoftRstAck = 1.
  - Stays while iSoftRstReq = 1.
  - iSoftRstReq = 0: ack drops on the next edge; counter = 0; go to HOLD. rstSync is still 1, so release re-runs immediately.

Timing
- From rstSync high: stage k releases exactly (k+1)*STAGE_DELAY edges later.
- iSoftRstReq high in RUN: first assertion on the next edge; oSoftRstAck rises NUM_STAGES+1 edges after the request is sampled.

Boundary conditions
- iSoftRstReq high during HOLD or RELEASE: ignored. The request is level, so it is honoured on arrival in RUN.
- iSoftRstReq dropped before ack (protocol violation): ASSERT still completes. ACK then lasts exactly one cycle.
- iRst_n asserted mid-sequence, in any state: immediate asynchronous return to reset values. No partial state survives.
- iRst_n glitch shorter than one cycle: the synchroniser chain is cleared, so the full SYNC_STAGES + delay sequence restarts.
- oStageRst_n bits only ever change in order: ascending on release, descending on assert.

Decomposition:
- Package reset_seq_pkg:
  - State encoding: HOLD, RELEASE, RUN, ASSERT, ACK, 3-bit.
  - Index-width function (clog2 of NUM_STAGES).
  - Parameter legality checks.
- One sub-module, reset_sync: SYNC_STAGES-deep async-assert, sync-deassert chain. It is reusable by other blocks.
- FSM, counter and output registers remain in reset_sequencer.

Test Plan:
1. Defaults; release iRst_n at edge 0 -> rstSync at edge 2; oStageRst_n goes 0001 at edge 18, 0011 at 34, 0111 at 50, 1111 at 66; oAllReleased and oBusy flip at edge 66.
2. In RUN, raise iSoftRstReq at edge E -> oStageRst_n = 0111, 0011, 0001, 0000 on edges E+1..E+4; oSoftRstAck = 1 at E+5. Drop req at F -> ack = 0 at F+1; stage 0 re-released at F+1+16.
3. Pull iRst_n low while oStageRst_n = 0011 -> all outputs return to reset values in the same cycle, asynchronously. Release -> full 66-edge sequence repeats from zero.
4. Hold iSoftRstReq high from before reset release -> release sequence completes to 1111, then one RUN cycle, then the assert sequence begins immediately.
5. Pulse iSoftRstReq for one cycle in RUN -> full assert sequence; oSoftRstAck high for exactly one cycle; re-release follows.
6. NUM_STAGES = 1, STAGE_DELAY = 1 -> oStageRst_n[0] rises one edge after rstSync. Soft reset asserts on E+1 and acks on E+2.
